// File: rtl/alu_nibble_sequencer.sv
// Request-side sequencer for the 4-bit ALU: streams a wide command through the ALU
// one nibble per cycle (LS first), chains the carry and returns the assembled result.
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_mode,
  input  logic [2:0]           req_op,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_c_in,
  output logic                 alu_mode,
  output logic [2:0]           alu_op,
  input  logic [3:0]           alu_out,
  input  logic                 alu_c_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_err
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_INC = 3'b110;

  typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;
  typedef enum logic [1:0] {CMD_LOGIC, CMD_ADD, CMD_INC, CMD_BAD} cmd_t;

  state_t        state;
  cmd_t          cmd_q;
  cmd_t          req_cmd_c;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [2:0]    op_q;
  logic [IW-1:0] idx;

  // Classify the incoming command; anything arithmetic other than add/increment is rejected.
  always_comb begin
    req_cmd_c = CMD_BAD;
    if (!req_mode)             req_cmd_c = CMD_LOGIC;
    else if (req_op == OP_ADD) req_cmd_c = CMD_ADD;
    else if (req_op == OP_INC) req_cmd_c = CMD_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= CMD_LOGIC;
      a_sh       <= '0;
      b_sh       <= '0;
      op_q       <= '0;
      idx        <= '0;
      req_ready  <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c_in   <= 1'b0;
      alu_mode   <= 1'b0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            cmd_q      <= req_cmd_c;
            a_sh       <= req_a >> 4;
            b_sh       <= req_b >> 4;
            op_q       <= req_op;
            idx        <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            if (req_cmd_c == CMD_BAD) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state    <= STEP;
              alu_a    <= req_a[3:0];
              alu_c_in <= 1'b0;
              case (req_cmd_c)
                CMD_ADD: begin
                  alu_mode <= 1'b1;
                  alu_op   <= OP_ADD;
                  alu_b    <= req_b[3:0];
                end
                CMD_INC: begin
                  alu_mode <= 1'b1;
                  alu_op   <= OP_INC;
                  alu_b    <= 4'b0001;
                end
                default: begin
                  alu_mode <= 1'b0;
                  alu_op   <= req_op;
                  alu_b    <= req_b[3:0];
                end
              endcase
            end
          end
        end

        STEP: begin
          rsp_result[{idx, 2'b00} +: 4] <= alu_out;
          if (idx == LAST_IDX) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_carry <= (cmd_q != CMD_LOGIC) && alu_c_out;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c_in  <= 1'b0;
            alu_mode  <= 1'b0;
            alu_op    <= '0;
          end else begin
            // Upper nibbles of an increment are an add of zero plus the chained carry.
            idx      <= idx + IW'(1);
            alu_a    <= a_sh[3:0];
            alu_b    <= (cmd_q == CMD_INC) ? 4'b0000 : b_sh[3:0];
            alu_op   <= (cmd_q == CMD_LOGIC) ? op_q : OP_ADD;
            alu_c_in <= (cmd_q != CMD_LOGIC) && alu_c_out;
            a_sh     <= a_sh >> 4;
            b_sh     <= b_sh >> 4;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU on the alu_* ports.
module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_mode;
  logic [2:0]  req_op;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_c_in;
  logic        alu_mode;
  logic [2:0]  alu_op;
  logic [3:0]  alu_out;
  logic        alu_c_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Behavioural ALU: logical ops in mode 0, add (010) and increment (110) in mode 1.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = 5'd0;
    if (alu_mode) begin
      if (alu_op == 3'b010)      alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c_in};
      else if (alu_op == 3'b110) alu_sum = {1'b0, alu_a} + 5'd1 + {4'b0, alu_c_in};
    end else begin
      case (alu_op)
        3'b000:  alu_sum = {1'b0, alu_a & alu_b};
        3'b001:  alu_sum = {1'b0, alu_a | alu_b};
        3'b010:  alu_sum = {1'b0, alu_a ^ alu_b};
        3'b011:  alu_sum = {1'b0, ~(alu_a & alu_b)};
        3'b100:  alu_sum = {1'b0, ~(alu_a | alu_b)};
        3'b101:  alu_sum = {1'b0, ~(alu_a ^ alu_b)};
        3'b110:  alu_sum = {1'b0, ~alu_a};
        default: alu_sum = {1'b0, ~alu_b};
      endcase
    end
  end
  assign alu_out   = alu_sum[3:0];
  assign alu_c_out = alu_sum[4];

  typedef struct {
    logic        mode;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        carry;
    logic        err;
    logic [3:0]  cins;  // alu_c_in seen on nibbles {3,2,1,0}
    int          lat;   // edges from accept (inclusive) to rsp_valid
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive one command; returns observed response fields. Leaves the response pending if !consume.
  task automatic run_cmd(input vec_t v, input bit consume, output int lat,
                         output logic [15:0] res, output logic c, output logic e,
                         output logic [3:0] cins, output logic alu_busy, output logic rdy_busy);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = v.mode;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    @(posedge clk);
    lat      = 99;
    cins     = 4'b0000;
    alu_busy = 1'b0;
    rdy_busy = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        alu_busy  = |{alu_a, alu_b, alu_c_in, alu_mode, alu_op};
        rdy_busy  = req_ready;
      end
      if (k <= 4 && !rsp_valid) cins[k-1] = alu_c_in;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    res = rsp_result;
    c   = rsp_carry;
    e   = rsp_err;
    if (consume && rsp_valid) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_handshake_valid", 32'(rsp_valid), 32'd0);
      check("post_handshake_ready", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] res;
    logic        c, e, alu_busy, rdy_busy;
    logic [3:0]  cins;
    logic        stable, leaked;
    vec_t        sv;

    //           mode  op      a         b         res       c     e     cins     lat
    vecs[0] = '{1'b1, 3'b010, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 4'b0110, 5};
    vecs[1] = '{1'b1, 3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'b1110, 5};
    vecs[2] = '{1'b0, 3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 4'b0000, 5};
    vecs[3] = '{1'b0, 3'b110, 16'h1234, 16'h5A5A, 16'hEDCB, 1'b0, 1'b0, 4'b0000, 5};
    vecs[4] = '{1'b1, 3'b110, 16'h0FFF, 16'h9999, 16'h1000, 1'b0, 1'b0, 4'b1110, 5};
    vecs[5] = '{1'b1, 3'b110, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b1110, 5};
    vecs[6] = '{1'b1, 3'b011, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b1, 4'b0000, 1};
    vecs[7] = '{1'b1, 3'b010, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 4'b0000, 5};
    vecs[8] = '{1'b0, 3'b001, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 4'b0000, 5};
    vecs[9] = '{1'b1, 3'b000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'b0000, 1};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mode = 1'b0; req_op = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_fields", 32'({rsp_result, rsp_carry, rsp_err}), 32'd0);
    check("reset_alu_outputs", 32'({alu_a, alu_b, alu_c_in, alu_mode, alu_op}), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i], 1'b1, lat, res, c, e, cins, alu_busy, rdy_busy);
      check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].carry));
      check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_ready", i), 32'(rdy_busy), 32'd0);
      if (vecs[i].err) check($sformatf("v%0d_alu_idle", i), 32'(alu_busy), 32'd0);
      else             check($sformatf("v%0d_c_in_seq", i), 32'(cins), 32'(vecs[i].cins));
    end

    // Back-pressure: response must hold while rsp_ready is low.
    sv = vecs[7];
    run_cmd(sv, 1'b0, lat, res, c, e, cins, alu_busy, rdy_busy);
    check("stall_latency", 32'(lat), 32'd5);
    stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== 16'h5555 || rsp_carry || rsp_err || req_ready)
        stable = 1'b0;
    end
    check("stall_hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_release_valid", 32'(rsp_valid), 32'd0);

    // Reset in the middle of STEP drops the command.
    req_valid = 1'b1; req_mode = 1'b1; req_op = 3'b010; req_a = 16'h00FF; req_b = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midstep_reset_ready", 32'(req_ready), 32'd1);
    check("midstep_reset_valid", 32'(rsp_valid), 32'd0);
    check("midstep_reset_alu", 32'({alu_a, alu_b, alu_c_in, alu_mode, alu_op}), 32'd0);
    leaked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) leaked = 1'b1;
    end
    check("midstep_reset_no_rsp", 32'(leaked), 32'd0);

    // Normal operation resumes after the reset.
    run_cmd(vecs[1], 1'b1, lat, res, c, e, cins, alu_busy, rdy_busy);
    check("after_reset_result", 32'(res), 32'h0000);
    check("after_reset_carry", 32'(c), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
